// File: rtl/snow64_sliced_lane_sequencer_pkg.sv
// Shared snow64 sliced-data types and lane helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Provides the integer lane-size enum, the SlicedData8/16/32/64 views of a
// 64-bit word, the sequencer state enum and lane count / extract / insert
// helpers shared by the lane sequencer and its lane extender.
package snow64_sliced_lane_sequencer_pkg;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        INT_TYPE_SIZE_8  = 2'd0,
        INT_TYPE_SIZE_16 = 2'd1,
        INT_TYPE_SIZE_32 = 2'd2,
        INT_TYPE_SIZE_64 = 2'd3
    } int_type_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // Lane 0 sits in the least significant bits of the 64-bit word.
    typedef struct packed { logic [7:0][7:0]  lanes; } sliced_data8_t;
    typedef struct packed { logic [3:0][15:0] lanes; } sliced_data16_t;
    typedef struct packed { logic [1:0][31:0] lanes; } sliced_data32_t;
    typedef struct packed { logic [0:0][63:0] lanes; } sliced_data64_t;

    function automatic logic [CNT_W-1:0] lane_count(input int_type_size_e sz);
        logic [CNT_W-1:0] n;
        case (sz)
            INT_TYPE_SIZE_8:  n = 4'd8;
            INT_TYPE_SIZE_16: n = 4'd4;
            INT_TYPE_SIZE_32: n = 4'd2;
            default:          n = 4'd1;
        endcase
        return n;
    endfunction

    // Pull lane idx out of d and widen it to 64 bits, sign- or zero-extended.
    function automatic logic [DATA_W-1:0] lane_extract_extend(
        input logic [DATA_W-1:0] d,
        input int_type_size_e    sz,
        input logic [2:0]        idx,
        input logic              sgn
    );
        sliced_data8_t  s8;
        sliced_data16_t s16;
        sliced_data32_t s32;
        sliced_data64_t s64;
        logic [7:0]  l8;
        logic [15:0] l16;
        logic [31:0] l32;
        logic [DATA_W-1:0] r;
        s8  = sliced_data8_t'(d);
        s16 = sliced_data16_t'(d);
        s32 = sliced_data32_t'(d);
        s64 = sliced_data64_t'(d);
        l8  = s8.lanes[idx];
        l16 = s16.lanes[idx[1:0]];
        l32 = s32.lanes[idx[0]];
        case (sz)
            INT_TYPE_SIZE_8:  r = {{56{sgn & l8[7]}}, l8};
            INT_TYPE_SIZE_16: r = {{48{sgn & l16[15]}}, l16};
            INT_TYPE_SIZE_32: r = {{32{sgn & l32[31]}}, l32};
            default:          r = s64.lanes[0];
        endcase
        return r;
    endfunction

    // Overwrite lane idx of r with the low lane-width bits of v.
    function automatic logic [DATA_W-1:0] lane_insert(
        input logic [DATA_W-1:0] r,
        input int_type_size_e    sz,
        input logic [2:0]        idx,
        input logic [DATA_W-1:0] v
    );
        sliced_data8_t  s8;
        sliced_data16_t s16;
        sliced_data32_t s32;
        sliced_data64_t s64;
        logic [DATA_W-1:0] o;
        s8  = sliced_data8_t'(r);
        s16 = sliced_data16_t'(r);
        s32 = sliced_data32_t'(r);
        s64 = sliced_data64_t'(r);
        s8.lanes[idx]         = v[7:0];
        s16.lanes[idx[1:0]]   = v[15:0];
        s32.lanes[idx[0]]     = v[31:0];
        s64.lanes[0]          = v;
        case (sz)
            INT_TYPE_SIZE_8:  o = s8;
            INT_TYPE_SIZE_16: o = s16;
            INT_TYPE_SIZE_32: o = s32;
            default:          o = s64;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/snow64_sliced_lane_sequencer_extender.sv
// Lane extract + sign/zero extend of a 64-bit sliced word.
// Latency: combinational (0 cycles).
// Backpressure: none; pure function of its inputs.
// Ports: i_data word, i_size lane size, i_index lane number, i_signed
// extension mode, o_data extended lane. With i_index=0 and i_signed=0 it
// doubles as a lane-width mask for the result-insert path.
module snow64_lane_extender
    import snow64_sliced_lane_sequencer_pkg::*;
(
    input  logic [DATA_W-1:0] i_data,
    input  int_type_size_e    i_size,
    input  logic [2:0]        i_index,
    input  logic              i_signed,
    output logic [DATA_W-1:0] o_data
);

    assign o_data = lane_extract_extend(i_data, i_size, i_index, i_signed);

endmodule

// File: rtl/snow64_sliced_lane_sequencer.sv
// Serialises a 64-bit sliced operand into lanes for a scalar unit and
// reassembles the in-order results. Latency: 2 + num_lanes cycles minimum.
// Backpressure: lane issue stalls on in_lane_ready / outstanding limit; result held until in_out_ready.
// Ports: start handshake (in_start/out_ready_for_start, in_data, size, signed),
// lane channel (out_lane_valid/in_lane_ready, out_lane_data, out_lane_index),
// result return (in_res_valid, in_res_data), output (out_valid/in_out_ready, out_data).
module snow64_sliced_lane_sequencer
    import snow64_sliced_lane_sequencer_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_start,
    output logic              out_ready_for_start,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_int_type_size,
    input  logic              in_signed,
    output logic              out_lane_valid,
    input  logic              in_lane_ready,
    output logic [DATA_W-1:0] out_lane_data,
    output logic [2:0]        out_lane_index,
    input  logic              in_res_valid,
    input  logic [DATA_W-1:0] in_res_data,
    output logic              out_valid,
    input  logic              in_out_ready,
    output logic [DATA_W-1:0] out_data
);

    localparam logic [CNT_W-1:0] MAX_OUT = CNT_W'(MAX_OUTSTANDING);

    seq_state_e        r_state;
    logic [DATA_W-1:0] r_operand;
    logic [DATA_W-1:0] r_result;
    int_type_size_e    r_size;
    logic              r_signed;
    logic [CNT_W-1:0]  r_issue_cnt;
    logic [CNT_W-1:0]  r_collect_cnt;
    logic              r_ready_for_start;
    logic              r_lane_valid;
    logic [DATA_W-1:0] r_lane_data;
    logic [2:0]        r_lane_index;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;

    logic              w_idle;
    logic              w_fire;
    logic              w_res_take;
    logic [CNT_W-1:0]  w_num;
    logic [CNT_W-1:0]  w_issue_nxt;
    logic [CNT_W-1:0]  w_collect_nxt;
    logic              w_lane_vld_nxt;
    logic              w_last_res;
    logic [DATA_W-1:0] w_ext_src;
    int_type_size_e    w_ext_size;
    logic              w_ext_signed;
    logic [2:0]        w_ext_index;
    logic [DATA_W-1:0] w_ext_lane;
    logic [DATA_W-1:0] w_res_masked;
    logic [DATA_W-1:0] w_result_ins;

    assign w_idle        = (r_state == ST_IDLE);
    assign w_num         = lane_count(r_size);
    assign w_fire        = r_lane_valid & in_lane_ready;
    // A result with nothing outstanding is a protocol error and is dropped.
    assign w_res_take    = (r_state == ST_RUN) & in_res_valid & (r_collect_cnt != r_issue_cnt);
    assign w_issue_nxt   = r_issue_cnt + {{(CNT_W-1){1'b0}}, w_fire};
    assign w_collect_nxt = r_collect_cnt + {{(CNT_W-1){1'b0}}, w_res_take};
    assign w_last_res    = w_res_take & (w_collect_nxt == w_num);
    // Outstanding count never exceeds num_lanes, so 4-bit subtraction cannot wrap.
    assign w_lane_vld_nxt = (w_issue_nxt < w_num) && ((w_issue_nxt - w_collect_nxt) < MAX_OUT);

    // In IDLE the extender looks at the live operand so lane 0 is registered
    // on the accept edge and presented in the very next cycle.
    assign w_ext_src    = w_idle ? in_data : r_operand;
    assign w_ext_size   = w_idle ? int_type_size_e'(in_int_type_size) : r_size;
    assign w_ext_signed = w_idle ? in_signed : r_signed;
    assign w_ext_index  = w_idle ? 3'd0 : w_issue_nxt[2:0];

    snow64_lane_extender u_issue_ext (
        .i_data   (w_ext_src),
        .i_size   (w_ext_size),
        .i_index  (w_ext_index),
        .i_signed (w_ext_signed),
        .o_data   (w_ext_lane)
    );

    // Zero-extending lane 0 of the raw result keeps only its lane-width bits.
    snow64_lane_extender u_res_mask (
        .i_data   (in_res_data),
        .i_size   (r_size),
        .i_index  (3'd0),
        .i_signed (1'b0),
        .o_data   (w_res_masked)
    );

    assign w_result_ins = lane_insert(r_result, r_size, r_collect_cnt[2:0], w_res_masked);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= ST_IDLE;
            r_operand         <= '0;
            r_result          <= '0;
            r_size            <= INT_TYPE_SIZE_8;
            r_signed          <= 1'b0;
            r_issue_cnt       <= '0;
            r_collect_cnt     <= '0;
            r_ready_for_start <= 1'b1;
            r_lane_valid      <= 1'b0;
            r_lane_data       <= '0;
            r_lane_index      <= '0;
            r_out_valid       <= 1'b0;
            r_out_data        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_start) begin
                        r_operand         <= in_data;
                        r_size            <= int_type_size_e'(in_int_type_size);
                        r_signed          <= in_signed;
                        r_issue_cnt       <= '0;
                        r_collect_cnt     <= '0;
                        r_result          <= '0;
                        r_ready_for_start <= 1'b0;
                        r_lane_valid      <= 1'b1;
                        r_lane_data       <= w_ext_lane;
                        r_lane_index      <= 3'd0;
                        r_state           <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_issue_cnt   <= w_issue_nxt;
                    r_collect_cnt <= w_collect_nxt;
                    if (w_res_take) begin
                        r_result <= w_result_ins;
                    end
                    r_lane_valid <= w_lane_vld_nxt;
                    // Only reload when a lane will be presented, so a stalled
                    // lane keeps its data and index until it fires.
                    if (w_lane_vld_nxt) begin
                        r_lane_data  <= w_ext_lane;
                        r_lane_index <= w_issue_nxt[2:0];
                    end
                    if (w_last_res) begin
                        r_lane_valid <= 1'b0;
                        r_out_valid  <= 1'b1;
                        r_out_data   <= w_result_ins;
                        r_state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (in_out_ready) begin
                        r_out_valid       <= 1'b0;
                        r_ready_for_start <= 1'b1;
                        r_state           <= ST_IDLE;
                    end
                end
                default: begin
                    r_state           <= ST_IDLE;
                    r_ready_for_start <= 1'b1;
                    r_lane_valid      <= 1'b0;
                    r_out_valid       <= 1'b0;
                end
            endcase
        end
    end

    assign out_ready_for_start = r_ready_for_start;
    assign out_lane_valid      = r_lane_valid;
    assign out_lane_data       = r_lane_data;
    assign out_lane_index      = r_lane_index;
    assign out_valid           = r_out_valid;
    assign out_data            = r_out_data;

endmodule

// File: tb/tb_snow64_sliced_lane_sequencer.sv
// Directed bench for the sliced lane sequencer with a small scalar-unit model.
// Inputs change #1 after posedge or at negedge; outputs sampled at negedge.
module tb_snow64_sliced_lane_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_start;
    logic        out_ready_for_start;
    logic [63:0] in_data;
    logic [1:0]  in_int_type_size;
    logic        in_signed;
    logic        out_lane_valid;
    logic        in_lane_ready;
    logic [63:0] out_lane_data;
    logic [2:0]  out_lane_index;
    logic        in_res_valid;
    logic [63:0] in_res_data;
    logic        out_valid;
    logic        in_out_ready;
    logic [63:0] out_data;

    int total = 0;
    int bad   = 0;

    logic [63:0] f_dat [8];
    logic [2:0]  f_idx [8];
    int          nfire;

    always #5 clk = ~clk;

    snow64_sliced_lane_sequencer #(.MAX_OUTSTANDING(4)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_start            (in_start),
        .out_ready_for_start (out_ready_for_start),
        .in_data             (in_data),
        .in_int_type_size    (in_int_type_size),
        .in_signed           (in_signed),
        .out_lane_valid      (out_lane_valid),
        .in_lane_ready       (in_lane_ready),
        .out_lane_data       (out_lane_data),
        .out_lane_index      (out_lane_index),
        .in_res_valid        (in_res_valid),
        .in_res_data         (in_res_data),
        .out_valid           (out_valid),
        .in_out_ready        (in_out_ready),
        .out_data            (out_data)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Runs one operation against a 1-cycle scalar unit (mode 0 echo, 1 add-one).
    // Optional stall of in_lane_ready on one lane and of in_out_ready in DONE.
    task automatic run_op(
        input  logic [63:0] d,
        input  logic [1:0]  sz,
        input  logic        sg,
        input  int          mode,
        input  int          lstall_idx,
        input  int          lstall_n,
        input  int          dstall_n,
        output logic [63:0] res,
        output int          vld_cyc,
        output int          idle_cyc,
        output int          nvalid,
        output bit          stable
    );
        logic [63:0] q[$];
        logic [63:0] hold_d;
        bit          held;
        int          lstall;
        int          dstall;
        lstall   = lstall_n;
        dstall   = dstall_n;
        held     = 1'b0;
        hold_d   = '0;
        res      = '0;
        vld_cyc  = -1;
        idle_cyc = -1;
        nvalid   = 0;
        stable   = 1'b1;
        nfire    = 0;
        in_data          = d;
        in_int_type_size = sz;
        in_signed        = sg;
        in_start         = 1'b1;
        in_lane_ready    = 1'b1;
        in_out_ready     = 1'b1;
        for (int cyc = 0; cyc < 200 && idle_cyc < 0; cyc++) begin
            if (q.size() > 0) begin
                in_res_valid = 1'b1;
                in_res_data  = q.pop_front();
            end else begin
                in_res_valid = 1'b0;
                in_res_data  = '0;
            end
            @(negedge clk);
            if (out_valid) begin
                nvalid++;
                if (vld_cyc < 0) begin
                    vld_cyc = cyc;
                    res     = out_data;
                end else if (out_data !== res) begin
                    stable = 1'b0;
                end
                if (dstall > 0) begin
                    in_out_ready = 1'b0;
                    dstall--;
                end else begin
                    in_out_ready = 1'b1;
                end
            end
            if (cyc > 0 && out_ready_for_start) idle_cyc = cyc;
            if (out_lane_valid && int'(out_lane_index) == lstall_idx && lstall > 0) begin
                if (!held) hold_d = out_lane_data;
                else if (out_lane_data !== hold_d) stable = 1'b0;
                held          = 1'b1;
                in_lane_ready = 1'b0;
                lstall--;
            end else begin
                in_lane_ready = 1'b1;
            end
            if (out_lane_valid && in_lane_ready) begin
                if (held) begin
                    if (out_lane_data !== hold_d || int'(out_lane_index) != lstall_idx) stable = 1'b0;
                    held = 1'b0;
                end
                if (nfire < 8) begin
                    f_dat[nfire] = out_lane_data;
                    f_idx[nfire] = out_lane_index;
                end
                nfire++;
                q.push_back((mode == 1) ? out_lane_data + 64'd1 : out_lane_data);
            end
            @(posedge clk);
            #1;
            in_start = 1'b0;
        end
        in_res_valid = 1'b0;
        in_res_data  = '0;
    endtask

    logic [63:0] exp8 [8];
    logic [63:0] r;
    int          vc, ic, nv, nf;
    bit          st;

    initial begin
        exp8[0] = 64'hFFFF_FFFF_FFFF_FF81;
        exp8[1] = 64'h0000_0000_0000_007E;
        exp8[2] = 64'h0000_0000_0000_007F;
        exp8[3] = 64'h0000_0000_0000_0003;
        exp8[4] = 64'h0000_0000_0000_0002;
        exp8[5] = 64'h0000_0000_0000_0001;
        exp8[6] = 64'hFFFF_FFFF_FFFF_FFFF;
        exp8[7] = 64'hFFFF_FFFF_FFFF_FF80;

        rst = 1'b1;
        in_start = 1'b0;
        in_data = '0;
        in_int_type_size = 2'd0;
        in_signed = 1'b0;
        in_lane_ready = 1'b0;
        in_res_valid = 1'b0;
        in_res_data = '0;
        in_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", out_ready_for_start, 1);
        chk("rst_lane_vld", out_lane_valid, 0);
        chk("rst_out_vld", out_valid, 0);
        chk("rst_lane_dat", out_lane_data, 0);
        chk("rst_lane_idx", out_lane_index, 0);
        chk("rst_out_dat", out_data, 0);
        rst = 1'b0;

        // 8-bit signed, echo unit
        run_op(64'h80FF_0102_037F_7E81, 2'd0, 1'b1, 0, -1, 0, 0, r, vc, ic, nv, st);
        chk("s8_nfire", nfire, 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("s8_lane%0d", i), f_dat[i], exp8[i]);
            chk($sformatf("s8_idx%0d", i), f_idx[i], i);
        end
        chk("s8_out", r, 64'h80FF_0102_037F_7E81);
        chk("s8_vld_cyc", vc, 10);

        // 16-bit unsigned, add-one, lane 2 stalled 5 cycles, DONE stalled 3 cycles
        run_op(64'h8000_0001_FFFF_1234, 2'd1, 1'b0, 1, 2, 5, 3, r, vc, ic, nv, st);
        chk("s16_out", r, 64'h8001_0002_0000_1235);
        chk("s16_lane2", f_dat[2], 64'h0000_0000_0000_0001);
        chk("s16_lane1_zext", f_dat[1], 64'h0000_0000_0000_FFFF);
        chk("s16_stable", st, 1);
        chk("s16_nvalid", nv, 4);
        chk("s16_idle_cyc", ic, vc + 4);

        // 64-bit, minimum latency
        run_op(64'h0000_0000_0000_1234, 2'd3, 1'b0, 1, -1, 0, 0, r, vc, ic, nv, st);
        chk("s64_out", r, 64'h1235);
        chk("s64_vld_cyc", vc, 3);
        chk("s64_idle_cyc", ic, 4);
        chk("s64_nvalid", nv, 1);

        // Outstanding limit: results withheld, stray result with nothing outstanding
        in_data = 64'h0807_0605_0403_0201;
        in_int_type_size = 2'd0;
        in_signed = 1'b0;
        in_lane_ready = 1'b1;
        in_start = 1'b1;
        @(posedge clk);
        #1;
        in_start = 1'b0;
        in_res_valid = 1'b1;
        in_res_data = 64'hAA;
        nf = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_lane_valid && in_lane_ready) nf++;
            @(posedge clk);
            #1;
            in_res_valid = 1'b0;
        end
        chk("maxout_fires", nf, 4);
        chk("maxout_block", out_lane_valid, 0);
        in_res_valid = 1'b1;
        in_res_data = 64'h01;
        nf = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_lane_valid && in_lane_ready) nf++;
            @(posedge clk);
            #1;
            in_res_valid = 1'b0;
        end
        chk("maxout_free", nf, 1);
        chk("maxout_idx", out_lane_index, 4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset after 3 of 8 lanes issued
        in_data = 64'h1122_3344_5566_7788;
        in_int_type_size = 2'd0;
        in_start = 1'b1;
        in_lane_ready = 1'b1;
        @(posedge clk);
        #1;
        in_start = 1'b0;
        nf = 0;
        for (int i = 0; i < 20 && nf < 3; i++) begin
            @(negedge clk);
            if (out_lane_valid && in_lane_ready) nf++;
            @(posedge clk);
            #1;
        end
        chk("mid_fires", nf, 3);
        rst = 1'b1;
        in_lane_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_lane_vld", out_lane_valid, 0);
        chk("mid_rst_ready", out_ready_for_start, 1);
        in_res_valid = 1'b1;
        in_res_data = 64'h55;
        @(posedge clk);
        #1;
        in_res_valid = 1'b0;
        chk("late_res_ready", out_ready_for_start, 1);
        chk("late_res_lane_vld", out_lane_valid, 0);
        chk("late_res_out_vld", out_valid, 0);

        run_op(64'hDEAD_BEEF_0000_0001, 2'd3, 1'b0, 0, -1, 0, 0, r, vc, ic, nv, st);
        chk("post_rst_out", r, 64'hDEAD_BEEF_0000_0001);
        chk("post_rst_vld_cyc", vc, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snow64_sliced_lane_sequencer.md
Name: snow64_sliced_lane_sequencer

Overview:
Serialises one 64-bit sliced vector operand (8x8, 4x16, 2x32 or 1x64 lanes) into individual lanes for a downstream scalar unit. It collects the in-order scalar results and reassembles them into a 64-bit sliced result. It sits directly upstream of and feeds the scalar lane datapath, and consumes operands formatted with the shared sliced-data struct types. One operation is in flight at a time. Lane issue and result collection overlap.

Parameters:
MAX_OUTSTANDING, 4, maximum lanes issued but not yet returned (1..8).

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
in_start  input  1  operation request; accepted when out_ready_for_start=1
out_ready_for_start  output  1  high only in IDLE
in_data  input  64  vector operand, sliced per in_int_type_size
in_int_type_size  input  2  0=8-bit, 1=16-bit, 2=32-bit, 3=64-bit lanes
in_signed  input  1  1: sign-extend lanes to 64 bits; 0: zero-extend
out_lane_valid  output  1  lane presented to scalar unit
in_lane_ready  input  1  scalar unit accepts lane
out_lane_data  output  64  extended lane value
out_lane_index  output  3  lane number 0..7
in_res_valid  input  1  scalar result valid (in order, one per cycle max)
in_res_data  input  64  result; only low lane-width bits used
out_valid  output  1  reassembled result valid
in_out_ready  input  1  consumer accepts result
out_data  output  64  reassembled sliced result

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. All state updates on posedge clk.
- Reset: state=IDLE, all counters=0, operand/result registers=0, out_lane_valid=0, out_valid=0, out_ready_for_start=1, out_lane_data=0, out_lane_index=0, out_data=0.
- Reset mid-operation drops everything without completing. Results arriving afterwards are ignored.
- Lane count: num_lanes = 8/4/2/1 for size 0/1/2/3.
- States:
  - IDLE: on in_start, latch in_data, size and signed; clear issue_cnt, collect_cnt and result register; go to RUN next cycle. in_start is ignored outside IDLE.
  - RUN: issue and collect lanes.
    - out_lane_valid = (issue_cnt < num_lanes) && ((issue_cnt - collect_cnt) < MAX_OUTSTANDING).
    - out_lane_index = issue_cnt.
    - out_lane_data = lane issue_cnt of the latched operand, extended per the latched in_signed.
    - Lane fire = out_lane_valid && in_lane_ready, then issue_cnt++.
    - out_lane_valid/out_lane_data/out_lane_index are registered. Once out_lane_valid is asserted, data and index are held stable until fire.
    - in_res_valid: write in_res_data[width-1:0] into slot collect_cnt of the result register, then collect_cnt++.
    - in_res_valid when collect_cnt == issue_cnt (nothing outstanding) is a protocol violation: ignore it, no state change.
    - Simultaneous fire and result in one cycle are both applied.
    - When the collected result is the last one (collect_cnt reaches num_lanes), go to DONE.
  - DONE: out_valid=1, out_data=result register, held stable until in_out_ready. On in_out_ready go to IDLE; out_valid drops the next cycle.
- Timing:
  - Minimum latency, start to out_valid, for 64-bit size with a 1-cycle scalar unit: start accepted cycle 0, lane fire cycle 1, result cycle 2, out_valid cycle 3.
  - 8-bit size with zero-latency ready and back-to-back results: out_valid at cycle 10.
- Counters are 4 bits. issue_cnt and collect_cnt never exceed num_lanes, and no wrap occurs.
- Any in_res_valid in IDLE or DONE is ignored.

Decomposition:
- Package (shared snow64 package): int type size enum; a lane-count function; a lane-extract-and-extend function over the SlicedData8/16/32/64 structs; a lane-insert function.
- Sub-module snow64_lane_extender: combinational 64-bit extract plus sign/zero extend selected by size, index and signed. It is reused by the result-insert path for masking.

Test Plan:
- size=0, signed=1, in_data=0x80FF_0102_037F_7E81, echo unit (res=lane) -> lanes 0..7 = 0xFFFF_FFFF_FFFF_FF81, 0x7E, 0x7F, 0x03, 0x02, 0x01, 0xFFFF_FFFF_FFFF_FFFF, 0xFFFF_FFFF_FFFF_FF80; out_data=0x80FF_0102_037F_7E81.
- size=1, signed=0, in_data=0x8000_0001_FFFF_1234, unit adds 1 -> out_data=0x8001_0002_0000_1235, with the 16-bit wrap kept in-lane.
- size=3, in_data=0x1234, 1-cycle unit, in_out_ready=1 -> out_valid at cycle 3, out_data=0x1235, back in IDLE at cycle 4.
- size=0, MAX_OUTSTANDING=4, unit withholds results -> exactly 4 lane fires. Then one result frees exactly one further fire.
- Backpressure: in_lane_ready low 5 cycles on lane 2 -> out_lane_index and out_lane_data held stable. Hold in_out_ready low 3 cycles in DONE -> out_valid and out_data stable throughout.
- Assert rst mid-RUN after 3 of 8 lanes -> next cycle out_lane_valid=0 and out_ready_for_start=1. A late in_res_valid is ignored. A new 64-bit operation completes correctly.
